// File: rtl/ultrasonic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ultrasonic_pkg
//  Description : Shared constants, FSM state type and BCD helper for the
//                ultrasonic echo-to-distance conversion path.
//                  CNT_W        - echo tick counter width
//                  TICKS_PER_CM - 50 MHz ticks per cm (58 us round trip)
//                  MAX_CM       - saturation distance (must fit DIST_W bits)
//                  BCD_BLANK    - digit code that blanks a seven-segment digit
//  Revision    : 1.0 - initial release
// ============================================================================
package ultrasonic_pkg;

    localparam int CNT_W        = 21;
    localparam int TICKS_PER_CM = 2900;
    localparam int MAX_CM       = 400;
    localparam int DIST_W       = 9;
    localparam int BCD_W        = 12;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        BCD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // after the next left shift, so bias it by 3 first.
    function automatic logic [3:0] dabble_adj(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential 9-bit binary to 3-digit BCD converter, one
//                double-dabble shift per cycle, 9 cycles per conversion.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start               - load bin and begin (1-cycle pulse)
//                bin[8:0]            - binary value, sampled with start
//                done                - high during the cycle of the final
//                                      shift; digits are valid from the next
//                                      cycle until the next start
//                hundreds/tens/ones  - BCD digits
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    import ultrasonic_pkg::*;

    localparam int          SH_W   = BCD_W + DIST_W;
    localparam logic [3:0]  SHIFTS = 4'(DIST_W);

    // [20:9] BCD digits, [8:0] binary bits still to be shifted in
    logic [SH_W-1:0] shreg_q, shreg_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic            run_q,   run_d;
    logic [SH_W-1:0] adj;

    always_comb begin
        adj = {dabble_adj(shreg_q[20:17]),
               dabble_adj(shreg_q[16:13]),
               dabble_adj(shreg_q[12:9]),
               shreg_q[8:0]};

        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        run_d   = run_q;

        if (start) begin
            shreg_d = {{BCD_W{1'b0}}, bin};
            cnt_d   = SHIFTS;
            run_d   = 1'b1;
        end else if (run_q) begin
            shreg_d = adj << 1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    assign done     = run_q && (cnt_q == 4'd1);
    assign hundreds = shreg_q[20:17];
    assign tens     = shreg_q[16:13];
    assign ones     = shreg_q[12:9];

endmodule
`default_nettype wire

// File: rtl/echo_distance_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : echo_distance_bcd
//  Description : Converts an echo-width tick count into whole centimetres by
//                sequential repeated subtraction, then into three BCD digits
//                for the seven-segment decoders.
//  Ports       : clk, rst_n            - 50 MHz clock, async active-low reset
//                meas_valid/meas_ticks - finished echo width (1-cycle strobe)
//                meas_timeout          - no echo within window (1-cycle strobe)
//                busy                  - conversion in progress
//                dist_valid            - 1-cycle strobe, results updated
//                dist_cm               - distance in cm, saturated at MAX_CM
//                bcd_hundreds/tens/ones- BCD digits (4'hF blanked on timeout)
//                out_of_range          - last result saturated or timed out
//                overrun               - 1-cycle strobe, input dropped (busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_distance_bcd #(
    parameter int CNT_W        = ultrasonic_pkg::CNT_W,
    parameter int TICKS_PER_CM = ultrasonic_pkg::TICKS_PER_CM,
    parameter int MAX_CM       = ultrasonic_pkg::MAX_CM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             meas_valid,
    input  logic [CNT_W-1:0] meas_ticks,
    input  logic             meas_timeout,
    output logic             busy,
    output logic             dist_valid,
    output logic [8:0]       dist_cm,
    output logic [3:0]       bcd_hundreds,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             out_of_range,
    output logic             overrun
);
    import ultrasonic_pkg::*;

    localparam logic [CNT_W-1:0]  TPC   = CNT_W'(TICKS_PER_CM);
    localparam logic [DIST_W-1:0] MAX_Q = DIST_W'(MAX_CM);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q,   rem_d;
    logic [DIST_W-1:0] q_q,     q_d;
    logic              sat_q,   sat_d;
    logic              blank_q, blank_d;   // result came from a timeout

    logic              dist_valid_q, dist_valid_d;
    logic [8:0]        dist_cm_q,    dist_cm_d;
    logic [3:0]        hund_q,       hund_d;
    logic [3:0]        tens_q,       tens_d;
    logic [3:0]        ones_q,       ones_d;
    logic              oor_q,        oor_d;
    logic              overrun_q,    overrun_d;

    logic              bcd_start;
    logic              bcd_done;
    logic [3:0]        bcd_h, bcd_t, bcd_o;

    bin2bcd_seq u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bcd_start),
        .bin      (q_q),
        .done     (bcd_done),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        q_d          = q_q;
        sat_d        = sat_q;
        blank_d      = blank_q;
        dist_cm_d    = dist_cm_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        oor_d        = oor_q;
        dist_valid_d = 1'b0;
        overrun_d    = 1'b0;
        bcd_start    = 1'b0;

        // Any strobe outside IDLE (DONE included) is dropped and flagged.
        if ((state_q != IDLE) && (meas_valid || meas_timeout)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (meas_timeout) begin
                    q_d     = MAX_Q;
                    sat_d   = 1'b1;
                    blank_d = 1'b1;
                    state_d = DONE;
                end else if (meas_valid) begin
                    rem_d   = meas_ticks;
                    q_d     = '0;
                    sat_d   = 1'b0;
                    blank_d = 1'b0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // Compare before subtracting so rem never wraps.
                if ((rem_q >= TPC) && (q_q < MAX_Q)) begin
                    rem_d = rem_q - TPC;
                    q_d   = q_q + 9'd1;
                end else begin
                    // Leftover of a whole cm means the cap cut the count short.
                    sat_d     = (rem_q >= TPC);
                    bcd_start = 1'b1;
                    state_d   = BCD;
                end
            end
            BCD: begin
                if (bcd_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dist_cm_d    = q_q;
                hund_d       = blank_q ? BCD_BLANK : bcd_h;
                tens_d       = blank_q ? BCD_BLANK : bcd_t;
                ones_d       = blank_q ? BCD_BLANK : bcd_o;
                oor_d        = sat_q;
                dist_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            q_q          <= '0;
            sat_q        <= 1'b0;
            blank_q      <= 1'b0;
            dist_valid_q <= 1'b0;
            dist_cm_q    <= '0;
            hund_q       <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            oor_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            q_q          <= q_d;
            sat_q        <= sat_d;
            blank_q      <= blank_d;
            dist_valid_q <= dist_valid_d;
            dist_cm_q    <= dist_cm_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            oor_q        <= oor_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign dist_valid   = dist_valid_q;
    assign dist_cm      = dist_cm_q;
    assign bcd_hundreds = hund_q;
    assign bcd_tens     = tens_q;
    assign bcd_ones     = ones_q;
    assign out_of_range = oor_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire
